icache_fetch_ctrl: RTL
======================

// Module: icache_fetch_ctrl
// PURPOSE
//  Fetch sequencer for the instruction cache + insmem pair. Owns the PC, advances it on
//  cache hits, and on a miss runs a refill: requests the line from instruction memory,
//  waits for the ack, writes the line into the cache, re-looks-up. Replaces delay-based
//  stalling with a synthesizable FSM and a valid/ready fetch handshake downstream.
// PARAMETERS
//  ADDR_WIDTH   32            PC / memory address width
//  LINE_WIDTH   128           cache line / insmem data width (bits); LINE_BYTES = LINE_WIDTH/8
//  PC_STEP      4             bytes per instruction
//  RESET_PC     32'hA75D53D8  PC after reset
// PORTS
//  clk             in   1           clock, rising edge
//  rst             in   1           asynchronous, active-high reset
//  pc              out  ADDR_WIDTH  current fetch address, drives cache lookup
//  cache_hit       in   1           combinational hit for pc, same cycle
//  fetch_valid     out  1           instruction at pc is valid (FETCH & cache_hit)
//  fetch_ready     in   1           consumer accepts instruction this cycle
//  redirect_valid  in   1           branch/jump: load redirect_pc
//  redirect_pc     in   ADDR_WIDTH  redirect target
//  mem_req         out  1           refill request, held until mem_ack
//  mem_addr        out  ADDR_WIDTH  line-aligned refill address
//  mem_ack         in   1           mem_rdata valid; ends request
//  mem_rdata       in   LINE_WIDTH  refill line
//  fill_en         out  1           one-cycle cache write strobe
//  fill_addr       out  ADDR_WIDTH  line address for fill (tag/set from it)
//  fill_data       out  LINE_WIDTH  line written to cache
//  busy            out  1           refill in progress (state != FETCH)
// BEHAVIOUR
//  - Reset (async): state=FETCH, pc=RESET_PC, pending redirect cleared, mem_req=0,
//    fill_en=0, mem_addr=0, fill_addr=0, fill_data=0, busy=0; fetch_valid follows cache_hit.
//  - States: FETCH, REQ, FILL, RETRY.
//  - FETCH: fetch_valid=cache_hit. Priority: redirect_valid -> pc<=redirect_pc (no fetch
//    counted); else hit&fetch_ready -> pc<=pc+PC_STEP; else hit&!ready -> hold;
//    else miss -> mem_addr<=pc & ~(LINE_BYTES-1), mem_req<=1, go REQ.
//  - REQ: mem_req=1, mem_addr stable until mem_ack sampled high. On mem_ack: latch
//    mem_rdata into fill_data, fill_addr<=mem_addr, mem_req<=0, go FILL. No timeout.
//  - FILL: fill_en=1 exactly one cycle; go RETRY.
//  - RETRY: one bubble cycle (cache write settles), fetch_valid=0; go FETCH.
//  - Miss-to-valid latency: 1 (REQ entry) + ack wait + 1 (FILL) + 1 (RETRY); with ack
//    on first REQ cycle, fetch_valid returns 4 cycles after miss cycle.
//  - Redirect while busy: refill is never aborted; redirect_pc captured in a pending
//    register (latest wins), applied to pc on RETRY->FETCH transition.
//  - Redirect and mem_ack same cycle: both taken (latch fill, capture redirect).
//  - pc arithmetic modulo 2^ADDR_WIDTH: 32'hFFFFFFFC + 4 -> 32'h00000000.
//  - pc unchanged in REQ/FILL/RETRY except pending-redirect load at RETRY exit.
//  - fetch_valid=0 in every state other than FETCH.
// CONFIGURATION
//  ICACHE_PERF_CNT_EN defined: adds outputs hit_count[31:0], miss_count[31:0];
//   hit_count +1 per FETCH cycle with hit&fetch_ready&!redirect_valid; miss_count +1 per
//   FETCH->REQ transition; both reset to 0, saturate at 32'hFFFFFFFF.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset: assert rst mid-cycle -> pc=32'hA75D53D8, mem_req=0, fill_en=0, busy=0 at once.
//  2 Hit stream: cache_hit=1, fetch_ready=1 for 5 cycles -> pc 0xA75D53D8..0xA75D53E8,
//    fetch_valid=1 each cycle; fetch_ready=0 one cycle -> pc held.
//  3 Miss: pc=0xA75D53D8, cache_hit=0, mem_ack after 3 REQ cycles -> mem_addr=0xA75D53D0,
//    mem_req high 3 cycles, fill_en 1 cycle with latched data, RETRY bubble, fetch resumes.
//  4 Redirect in REQ: redirect_pc=0x00001000 -> refill completes to 0xA75D53D0, then
//    pc=0x00001000 after RETRY; second redirect 0x2000 in FILL -> 0x2000 wins.
//  5 Wrap: pc via redirect to 0xFFFFFFFC, hit&ready -> pc=0x00000000.
//  6 Perf (ICACHE_PERF_CNT_EN): 3 hits, 1 miss, 1 redirect cycle -> hit_count=3,
//    miss_count=1; rst -> both 0.

Source files
------------

// File: rtl/icache_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, streams cache hits downstream and runs line refills on misses.
// Optional hit/miss performance counters are enabled with `define ICACHE_PERF_CNT_EN.
module icache_fetch_ctrl #(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            LINE_WIDTH = 128,
    parameter int unsigned            PC_STEP    = 4,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = 32'hA75D53D8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] pc,
    input  logic                  cache_hit,
    output logic                  fetch_valid,
    input  logic                  fetch_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    output logic                  fill_en,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [LINE_WIDTH-1:0] fill_data,
    output logic                  busy
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int unsigned           LINE_BYTES = LINE_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK  = ~ADDR_WIDTH'(LINE_BYTES - 1);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_REQ   = 2'd1,
        S_FILL  = 2'd2,
        S_RETRY = 2'd3
    } state_t;

    state_t                state;
    logic                  pend_valid;
    logic [ADDR_WIDTH-1:0] pend_pc;

    // Hit is looked up combinationally on the current pc, so valid tracks it in the same cycle.
    assign fetch_valid = (state == S_FETCH) && cache_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            pend_valid <= 1'b0;
            pend_pc    <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            fill_en    <= 1'b0;
            fill_addr  <= '0;
            fill_data  <= '0;
            busy       <= 1'b0;
        end else begin
            fill_en <= 1'b0;

            // A refill is never aborted; redirects seen meanwhile are parked, latest wins.
            if (state != S_FETCH && redirect_valid) begin
                pend_valid <= 1'b1;
                pend_pc    <= redirect_pc;
            end

            case (state)
                S_FETCH: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end else if (cache_hit && fetch_ready) begin
                        pc <= pc + ADDR_WIDTH'(PC_STEP);
                    end else if (!cache_hit) begin
                        mem_addr <= pc & LINE_MASK;
                        mem_req  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        fill_data <= mem_rdata;
                        fill_addr <= mem_addr;
                        mem_req   <= 1'b0;
                        fill_en   <= 1'b1;
                        state     <= S_FILL;
                    end
                end
                S_FILL: begin
                    state <= S_RETRY;
                end
                S_RETRY: begin
                    state      <= S_FETCH;
                    busy       <= 1'b0;
                    pend_valid <= 1'b0;
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end else if (pend_valid) begin
                        pc <= pend_pc;
                    end
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    // Saturating event counters for accepted fetches and refill starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == S_FETCH && !redirect_valid) begin
            if (cache_hit && fetch_ready && hit_count != 32'hFFFF_FFFF) begin
                hit_count <= hit_count + 32'd1;
            end
            if (!cache_hit && miss_count != 32'hFFFF_FFFF) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule
